// File: rtl/acl_spi_sequencer.sv
// acl_spi_sequencer: runs the accelerometer power-up configuration and then
// issues periodic Z-axis burst reads through a byte-level SPI shift engine.
// It publishes each signed 16-bit Z sample with a one-cycle valid strobe.
module acl_spi_sequencer #(
  parameter int         CLK_HZ        = 100_000_000,
  parameter int         SAMPLE_HZ     = 100,
  parameter int         PWRUP_CYC     = 500_000,
  parameter int         SRST_WAIT_CYC = 50_000,
  parameter int         CS_GAP_CYC    = 20,
  parameter int         TIMEOUT_CYC   = 4096,
  parameter logic [7:0] FILTER_VAL    = 8'h13,
  parameter logic [7:0] PWR_VAL       = 8'h02
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx,
  output logic        acl_cs_n,
  output logic [15:0] z_raw,
  output logic        z_valid,
  output logic        init_done,
  output logic        err,
  output logic [7:0]  overrun_cnt
);

  localparam int          P          = CLK_HZ / SAMPLE_HZ;
  localparam logic [31:0] PWRUP_LAST = 32'(PWRUP_CYC - 1);
  localparam logic [31:0] SRST_LAST  = 32'(SRST_WAIT_CYC - 1);
  localparam logic [31:0] GAP_LAST   = 32'(CS_GAP_CYC - 1);
  localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] P_LAST     = 32'(P - 1);

  // Transaction phases; which transaction is running is tracked separately in txn.
  typedef enum logic [2:0] {
    S_PWRUP, S_SRST_WAIT, S_IDLE, S_CS, S_START, S_WAIT, S_GAP
  } state_t;

  // T_RECOVER marks the chip-select gap that follows a timeout.
  typedef enum logic [2:0] {
    T_SRST, T_FILT, T_PWR, T_READ, T_RECOVER
  } txn_t;

  state_t      state, state_d;
  txn_t        txn, txn_d;
  logic [1:0]  idx, idx_d;
  logic [31:0] tmr, samp_cnt;
  logic        pending, run, tick, last_byte, timeout, start_read, rx_ok;
  logic [7:0]  z_lo;

  // Byte sent at position i of transaction t.
  function automatic logic [7:0] tx_byte(input txn_t t, input logic [1:0] i);
    logic [7:0] b;
    b = 8'h00;
    case (t)
      T_SRST: b = (i == 2'd0) ? 8'h0A : (i == 2'd1) ? 8'h1F : 8'h52;
      T_FILT: b = (i == 2'd0) ? 8'h0A : (i == 2'd1) ? 8'h2C : FILTER_VAL;
      T_PWR:  b = (i == 2'd0) ? 8'h0A : (i == 2'd1) ? 8'h2D : PWR_VAL;
      T_READ: b = (i == 2'd0) ? 8'h0B : (i == 2'd1) ? 8'h12 : 8'h00;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Saturating 8-bit increment.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign run        = init_done && en;
  assign tick       = run && (samp_cnt == P_LAST);
  assign last_byte  = (txn == T_READ) ? (idx == 2'd3) : (idx == 2'd2);
  assign rx_ok      = (state == S_WAIT) && spi_done;
  assign timeout    = (state == S_WAIT) && !spi_done && (tmr == TMO_LAST);
  assign start_read = (state == S_IDLE) && (state_d == S_CS);
  assign acl_cs_n   = !((state == S_CS) || (state == S_START) || (state == S_WAIT));
  assign spi_start  = (state == S_START);

  // Next-state logic: phase sequencing and transaction selection.
  always_comb begin
    state_d = state;
    txn_d   = txn;
    idx_d   = idx;
    case (state)
      S_PWRUP: if (tmr == PWRUP_LAST) begin
        state_d = S_CS; txn_d = T_SRST; idx_d = 2'd0;
      end
      S_SRST_WAIT: if (tmr == SRST_LAST) begin
        state_d = S_CS; txn_d = T_FILT; idx_d = 2'd0;
      end
      S_IDLE: if (en && (tick || pending)) begin
        state_d = S_CS; txn_d = T_READ; idx_d = 2'd0;
      end
      S_CS:    state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (spi_done) begin
          if (last_byte) state_d = S_GAP;
          else begin
            state_d = S_START; idx_d = idx + 2'd1;
          end
        end else if (tmr == TMO_LAST) begin
          state_d = S_GAP; txn_d = T_RECOVER;
        end
      end
      S_GAP: if (tmr == GAP_LAST) begin
        case (txn)
          T_SRST:    state_d = S_SRST_WAIT;
          T_FILT:    begin state_d = S_CS; txn_d = T_PWR;  idx_d = 2'd0; end
          T_RECOVER: begin state_d = S_CS; txn_d = T_SRST; idx_d = 2'd0; end
          default:   state_d = S_IDLE;
        endcase
      end
      default: state_d = S_PWRUP;
    endcase
  end

  // State register; the phase timer restarts on every phase change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_PWRUP;
      txn   <= T_SRST;
      idx   <= 2'd0;
      tmr   <= '0;
    end else begin
      state <= state_d;
      txn   <= txn_d;
      idx   <= idx_d;
      tmr   <= (state_d != state) ? '0 : tmr + 32'd1;
    end
  end

  // Transmit byte loads on entry to the start phase and holds until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spi_tx <= 8'h00;
    else if (state_d == S_START) spi_tx <= tx_byte(txn_d, idx_d);
  end

  // Sample-rate timer, free-running only while configured and enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) samp_cnt <= '0;
    else if (!run || samp_cnt == P_LAST) samp_cnt <= '0;
    else samp_cnt <= samp_cnt + 32'd1;
  end

  // Pending request and dropped-tick accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= 1'b0;
      overrun_cnt <= 8'h00;
    end else begin
      if (!en || timeout || start_read) pending <= 1'b0;
      else if (tick && state != S_IDLE) pending <= 1'b1;
      if (tick && pending && !start_read) overrun_cnt <= sat_inc8(overrun_cnt);
    end
  end

  // Configuration status: init_done after the power-control gap, err sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done <= 1'b0;
      err       <= 1'b0;
    end else if (timeout) begin
      init_done <= 1'b0;
      err       <= 1'b1;
    end else if (state == S_GAP && tmr == GAP_LAST && txn == T_PWR) begin
      init_done <= 1'b1;
    end
  end

  // Low Z byte holding register.
  always_ff @(posedge clk) begin
    if (rx_ok && txn == T_READ && idx == 2'd2) z_lo <= spi_rx;
  end

  // Publish {ZDATA_H, ZDATA_L} with a one-cycle strobe after the last byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_raw   <= 16'h0000;
      z_valid <= 1'b0;
    end else begin
      z_valid <= 1'b0;
      if (rx_ok && txn == T_READ && idx == 2'd3) begin
        z_raw   <= {spi_rx, z_lo};
        z_valid <= 1'b1;
      end
    end
  end

endmodule
